// File: rtl/xulie_decoder_if.sv
// -----------------------------------------------------------------------------
// xulie_decoder_if
//   Bundles the serial pattern line and the decoder's result signals.
//   Optional feature macro: XULIE_DEC_HITCNT_EN (adds the 16-bit hit_cnt signal).
//
//   Signals:
//     din        serial pattern line, asynchronous to the decoder clock
//     bit_valid  one-cycle pulse, a new bit was sampled
//     bit_data   sampled bit value, valid with bit_valid
//     window     last BITS sampled bits, newest in LSB
//     match      one-cycle pulse, window equals the expected pattern
//     lock       level, a match occurred within the last LOCK_WIN samples
//     hit_cnt    saturating match counter (XULIE_DEC_HITCNT_EN only)
//
//   Modports:
//     master  line side / observer: drives din, reads results
//     slave   decoder side: reads din, drives results
// -----------------------------------------------------------------------------
interface xulie_decoder_if #(
  parameter int BITS = 10
);
  logic            din;
  logic            bit_valid;
  logic            bit_data;
  logic [BITS-1:0] window;
  logic            match;
  logic            lock;
`ifdef XULIE_DEC_HITCNT_EN
  logic [15:0]     hit_cnt;

  modport master (output din, input bit_valid, input bit_data, input window,
                  input match, input lock, input hit_cnt);
  modport slave  (input din, output bit_valid, output bit_data, output window,
                  output match, output lock, output hit_cnt);
`else
  modport master (output din, input bit_valid, input bit_data, input window,
                  input match, input lock);
  modport slave  (input din, output bit_valid, output bit_data, output window,
                  output match, output lock);
`endif
endinterface

// File: rtl/xulie_decoder.sv
// -----------------------------------------------------------------------------
// xulie_decoder
//   Consumer of the serial pattern line. Synchronises din, recovers bit timing
//   from line transitions, samples each bit cell at SAMPLE_PT, keeps a sliding
//   BITS-wide window and pulses match whenever the window holds EXPECT. lock
//   stays high while matches recur within LOCK_WIN samples.
//   Optional feature macro: XULIE_DEC_HITCNT_EN (saturating 16-bit match
//   counter on bus.hit_cnt).
//
//   Ports:
//     clk  in  system clock (50 MHz)
//     rst  in  asynchronous reset, active-high
//     bus  xulie_decoder_if.slave: din in; bit_valid, bit_data, window, match,
//          lock (and hit_cnt) out, all registered
// -----------------------------------------------------------------------------
module xulie_decoder #(
  parameter int              BIT_CYCLES = 49,
  parameter int              SAMPLE_PT  = 24,
  parameter int              BITS       = 10,
  parameter logic [BITS-1:0] EXPECT     = 10'h2D3,
  parameter int              LOCK_WIN   = 20
) (
  input  logic           clk,
  input  logic           rst,
  xulie_decoder_if.slave bus
);

  localparam int PH_W   = $clog2(BIT_CYCLES);
  localparam int FILL_W = $clog2(BITS + 1);
  localparam int GAP_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    LOCK  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              sync_q, sync_qq;
  logic              line_edge;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [FILL_W-1:0] fill_q, fill_nx;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [BITS-1:0]   window_q, window_nx;
  logic              sample, hit;
  logic              bit_valid_q, bit_data_q, match_q, lock_q;

  // Either polarity of a synchronised transition realigns the bit clock.
  assign line_edge = sync_q ^ sync_qq;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sample    = 1'b0;
    window_nx = {window_q[BITS-2:0], sync_q};
    fill_nx   = fill_q;
    hit       = 1'b0;
    phase_d   = phase_q + PH_W'(1);
    state_d   = state_q;
    gap_d     = gap_q;

    // An edge landing on the sample point wins: the cell is re-timed, not sampled.
    sample  = (state_q != IDLE) && !line_edge && (phase_q == PH_W'(SAMPLE_PT));
    fill_nx = (fill_q == FILL_W'(BITS)) ? fill_q : fill_q + FILL_W'(1);
    hit     = sample && (fill_nx == FILL_W'(BITS)) && (window_nx == EXPECT);

    // Phase is parked at 0 until the first edge; afterwards it free-runs so
    // long constant runs still produce one sample per bit cell.
    if (state_q == IDLE || line_edge || phase_q == PH_W'(BIT_CYCLES - 1)) begin
      phase_d = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (line_edge) state_d = TRACK;
      end
      TRACK: begin
        if (hit) begin
          state_d = LOCK;
          gap_d   = '0;
        end
      end
      LOCK: begin
        if (hit) begin
          gap_d = '0;
        end else if (sample) begin
          // The LOCK_WIN-th consecutive sample without a match drops lock;
          // fill and window are kept so the next match can re-lock at once.
          if (gap_q == GAP_W'(LOCK_WIN - 1)) begin
            state_d = TRACK;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= 1'b0;
      sync_qq     <= 1'b0;
      phase_q     <= '0;
      fill_q      <= '0;
      gap_q       <= '0;
      window_q    <= '0;
      bit_valid_q <= 1'b0;
      bit_data_q  <= 1'b0;
      match_q     <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      sync_q      <= bus.din;
      sync_qq     <= sync_q;
      phase_q     <= phase_d;
      gap_q       <= gap_d;
      bit_valid_q <= sample;
      match_q     <= hit;
      lock_q      <= (state_d == LOCK);
      if (sample) begin
        window_q   <= window_nx;
        fill_q     <= fill_nx;
        bit_data_q <= sync_q;
      end
    end
  end

`ifdef XULIE_DEC_HITCNT_EN
  logic [15:0] hit_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q <= '0;
    end else if (hit && hit_cnt_q != 16'hFFFF) begin
      hit_cnt_q <= hit_cnt_q + 16'd1;
    end
  end

  assign bus.hit_cnt = hit_cnt_q;
`endif

  assign bus.bit_valid = bit_valid_q;
  assign bus.bit_data  = bit_data_q;
  assign bus.window    = window_q;
  assign bus.match     = match_q;
  assign bus.lock      = lock_q;

endmodule

// File: tb/tb_xulie_decoder.sv
// -----------------------------------------------------------------------------
// tb_xulie_decoder
//   Self-checking bench for xulie_decoder. A behavioural model derives every
//   output from the line history: phase is the time since the last re-timing
//   event modulo BIT_CYCLES, the window is a queue of sampled bits, and lock is
//   "fewer than LOCK_WIN samples since the last match". A monitor compares the
//   DUT against the model one step after every rising clock edge; the directed
//   sequence adds literal expectations for reset, frame decoding, corruption,
//   lock loss, edge/sample coincidence, random runs and mid-frame reset.
//   Optional feature macro: XULIE_DEC_HITCNT_EN (hit_cnt is also checked).
// -----------------------------------------------------------------------------
module tb_xulie_decoder;

  localparam int         BIT_CYCLES = 49;
  localparam int         SAMPLE_PT  = 24;
  localparam int         BITS       = 10;
  localparam logic [9:0] EXPECT     = 10'h2D3;
  localparam int         LOCK_WIN   = 20;

  logic clk = 1'b0;
  logic rst;

  always #10 clk = ~clk;

  xulie_decoder_if #(.BITS(BITS)) bus ();

  xulie_decoder #(
    .BIT_CYCLES(BIT_CYCLES),
    .SAMPLE_PT (SAMPLE_PT),
    .BITS      (BITS),
    .EXPECT    (EXPECT),
    .LOCK_WIN  (LOCK_WIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  bit         m_q1, m_q2, m_started, m_matched;
  int         m_cyc, m_zero, m_nsamp, m_last_match;
  bit         m_bits[$];
  logic       e_bv, e_bd, e_match, e_lock;
  logic [9:0] e_win;
  int         e_hit;

  task model_step();
    bit edge_seen, smp;
    int phase_pre;
    m_cyc++;
    if (rst) begin
      m_q1 = 0; m_q2 = 0; m_started = 0; m_matched = 0;
      m_zero = m_cyc; m_nsamp = 0; m_last_match = 0;
      m_bits.delete();
      e_bv = 0; e_bd = 0; e_match = 0; e_lock = 0; e_win = '0; e_hit = 0;
      return;
    end
    edge_seen = (m_q1 != m_q2);
    phase_pre = (m_cyc - 1 - m_zero) % BIT_CYCLES;
    smp       = m_started && !edge_seen && (phase_pre == SAMPLE_PT);
    if (!m_started || edge_seen) m_zero = m_cyc;
    if (edge_seen) m_started = 1;
    e_bv    = smp;
    e_match = 0;
    if (smp) begin
      e_bd = m_q1;
      m_bits.push_back(m_q1);
      if (m_bits.size() > BITS) void'(m_bits.pop_front());
      m_nsamp++;
      e_win = '0;
      foreach (m_bits[i]) e_win = {e_win[8:0], m_bits[i]};
      if (m_bits.size() == BITS && e_win == EXPECT) begin
        e_match      = 1;
        m_matched    = 1;
        m_last_match = m_nsamp;
        if (e_hit < 65535) e_hit++;
      end
    end
    e_lock = m_matched && ((m_nsamp - m_last_match) < LOCK_WIN);
    m_q2 = m_q1;
    m_q1 = bus.din;
  endtask

  // ------------------------------------------------------- monitor/compare
  int bv_cnt = 0, mt_cnt = 0, unlock_cnt = 0;
  int since_rst_bv = 0, first_match_bv = -1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      model_step();
      check("bit_valid", bus.bit_valid, e_bv);
      if (e_bv) check("bit_data", bus.bit_data, e_bd);
      check("window", bus.window, e_win);
      check("match", bus.match, e_match);
      check("lock", bus.lock, e_lock);
`ifdef XULIE_DEC_HITCNT_EN
      check("hit_cnt", bus.hit_cnt, e_hit);
`endif
      if (rst) begin
        since_rst_bv   = 0;
        first_match_bv = -1;
      end
      if (bus.bit_valid) begin
        bv_cnt++;
        since_rst_bv++;
      end
      if (bus.match) begin
        mt_cnt++;
        if (first_match_bv < 0) first_match_bv = since_rst_bv;
      end
      if (!bus.lock) unlock_cnt++;
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick(input bit v);
    @(negedge clk);
    bus.din = v;
  endtask

  // Generator frame: 1011010011, 49 clocks per cell, 500-clock frame.
  // corrupt holds the fifth cell (196-244) high.
  function automatic bit frame_level(input int t, input bit corrupt);
    if (t < 49)  return 1'b1;
    if (t < 98)  return 1'b0;
    if (t < 196) return 1'b1;
    if (t < 245) return corrupt;
    if (t < 294) return 1'b1;
    if (t < 392) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_frame(input bit corrupt, input int upto, output int bv, output int mt);
    bv_cnt = 0;
    mt_cnt = 0;
    for (int t = 0; t < upto; t++) tick(frame_level(t, corrupt));
    bv = bv_cnt;
    mt = mt_cnt;
  endtask

  initial begin
    int bv1, mt1, bv2, mt2, bv3, mt3, bvx, mtx;
    bit lvl;
    int len;

    rst     = 1'b0;
    bus.din = 1'b0;
    #1 rst  = 1'b1;

    // Reset held with the line toggling: everything stays cleared.
    for (int i = 0; i < 5; i++) tick(i[0]);
    check("rst_bit_valid", bus.bit_valid, 0);
    check("rst_window", bus.window, 0);
    check("rst_match", bus.match, 0);
    check("rst_lock", bus.lock, 0);
    @(negedge clk);
    bus.din = 1'b0;
    rst     = 1'b0;

    // Static line: IDLE never samples without an edge.
    bv_cnt = 0;
    repeat (300) tick(1'b0);
    check("static_no_sample", bv_cnt, 0);

    // Clean frames.
    run_frame(1'b0, 500, bv1, mt1);
    run_frame(1'b0, 500, bv2, mt2);
    run_frame(1'b0, 500, bv3, mt3);
    check("frame1_samples", bv1, 10);
    check("first_match_by_frame2", (mt1 + mt2) >= 1, 1);
    check("frame3_samples", bv3, 10);
    check("frame3_matches", mt3, 1);
    check("locked_after_match", bus.lock, 1);
    check("window_after_frame", bus.window, 10'h2D3);

    // One corrupted frame: no match, lock held, matching resumes.
    unlock_cnt = 0;
    run_frame(1'b1, 500, bvx, mtx);
    check("corrupt_samples", bvx, 10);
    check("corrupt_no_match", mtx, 0);
    run_frame(1'b0, 500, bvx, mtx);
    check("resume_match", mtx, 1);
    check("lock_held_through_corruption", unlock_cnt, 0);

    // Constant line after the last match: lock falls on the 20th sample.
    bv_cnt = 0;
    for (int i = 0; i < 3000 && bus.lock; i++) tick(1'b1);
    check("lock_dropped", bus.lock, 0);
    check("samples_to_unlock", bv_cnt, LOCK_WIN);

    // Second edge 25 clocks after the first lands on phase 24: no sample there.
    tick(1'b0);
    repeat (24) tick(1'b0);
    tick(1'b1);
    bv_cnt = 0;
    repeat (20) tick(1'b1);
    check("coincident_no_sample", bv_cnt, 0);
    repeat (10) tick(1'b1);
    check("sample_after_retime", bv_cnt, 1);

    // Random run lengths, checked by the model.
    for (int r = 0; r < 40; r++) begin
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 150));
      repeat (len) tick(lvl);
    end

    // Re-lock, then reset at frame clock 300.
    run_frame(1'b0, 500, bvx, mtx);
    run_frame(1'b0, 500, bvx, mtx);
    run_frame(1'b0, 500, bvx, mtx);
    check("relocked", bus.lock, 1);
    run_frame(1'b0, 300, bvx, mtx);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_lock", bus.lock, 0);
    check("midrst_window", bus.window, 0);
    check("midrst_bit_valid", bus.bit_valid, 0);
`ifdef XULIE_DEC_HITCNT_EN
    check("midrst_hit_cnt", bus.hit_cnt, 0);
`endif
    repeat (4) tick(1'b0);
    @(negedge clk);
    rst     = 1'b0;
    bus.din = 1'b0;

    mt_cnt = 0;
    run_frame(1'b0, 500, bv1, mt1);
    run_frame(1'b0, 500, bv2, mt2);
    run_frame(1'b0, 500, bv3, mt3);
    check("reacq_min_samples", first_match_bv >= BITS, 1);
    check("reacq_matches", mt1 + mt2 + mt3, 3);
`ifdef XULIE_DEC_HITCNT_EN
    check("hit_cnt_three", bus.hit_cnt, 3);
`endif

    repeat (5) tick(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
